// File: rtl/adc_duty_map_if.sv
`default_nettype none
// ============================================================================
// Module    : adc_duty_map_if
// Purpose   : Groups the sample handshake and duty-code outputs of
//             adc_duty_map into one bundle.
// Signals   : en            - block enable (master -> slave)
//             sample_data   - unsigned ADC result (master -> slave)
//             sample_valid  - sample_data holds a new result (master -> slave)
//             sample_ready  - block can take a sample (slave -> master)
//             duty_cycle    - 3-bit duty code (slave -> master)
//             duty_valid    - one-cycle update pulse (slave -> master)
// Revision  : 1.0 - initial release
// ============================================================================
interface adc_duty_map_if #(
  parameter int ADC_WIDTH = 12
);
  logic                 en;
  logic [ADC_WIDTH-1:0] sample_data;
  logic                 sample_valid;
  logic                 sample_ready;
  logic [2:0]           duty_cycle;
  logic                 duty_valid;

  modport master (
    output en,
    output sample_data,
    output sample_valid,
    input  sample_ready,
    input  duty_cycle,
    input  duty_valid
  );

  modport slave (
    input  en,
    input  sample_data,
    input  sample_valid,
    output sample_ready,
    output duty_cycle,
    output duty_valid
  );
endinterface
`default_nettype wire

// File: rtl/adc_duty_map.sv
`default_nettype none
// ============================================================================
// Module    : adc_duty_map
// Purpose   : Averages 2^AVG_LOG2 ADC samples and maps the top three bits of
//             the average onto a 3-bit PWM duty code.
// Ports     : clk    - system clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - adc_duty_map_if slave modport (en, sample handshake,
//                      duty_cycle / duty_valid outputs)
// Params    : ADC_WIDTH (>=4) sample width, AVG_LOG2 (1..6) log2 of the
//             averaging depth.
// Options   : ADC_DUTY_HYST_EN - when defined, one-step duty changes are
//             filtered by the bit just below the candidate code.
// Revision  : 1.0 - initial release
// ============================================================================
module adc_duty_map #(
  parameter int ADC_WIDTH = 12,
  parameter int AVG_LOG2  = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  adc_duty_map_if.slave     bus
);

  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_MAP    = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t               r_state;
  logic [ACC_W-1:0]     r_acc;
  logic [AVG_LOG2-1:0]  r_cnt;
  logic [2:0]           r_cand;
  logic [2:0]           r_duty;
  logic                 r_duty_valid;
  // Held low through reset and set on the first edge after release so that
  // sample_ready cannot assert while rst_n is still low.
  logic                 r_run;
  logic                 w_ready;
  logic                 w_accept;
  logic [2:0]           w_next_duty;

  assign w_ready  = r_run && bus.en && (r_state == ST_ACCUM);
  assign w_accept = w_ready && bus.sample_valid;

`ifdef ADC_DUTY_HYST_EN
  // avg[ADC_WIDTH-4]: tells whether the average sits in the upper or lower
  // half of the candidate's bin; a one-step move is only taken when the
  // average is already well inside the new bin.
  logic r_hbit;

  always_comb begin
    w_next_duty = r_cand;
    if (({1'b0, r_cand} == ({1'b0, r_duty} + 4'd1)) && !r_hbit) begin
      w_next_duty = r_duty;
    end else if ((({1'b0, r_cand} + 4'd1) == {1'b0, r_duty}) && r_hbit) begin
      w_next_duty = r_duty;
    end
  end
`else
  assign w_next_duty = r_cand;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ACCUM;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_cand       <= 3'd0;
      r_duty       <= 3'd0;
      r_duty_valid <= 1'b0;
      r_run        <= 1'b0;
`ifdef ADC_DUTY_HYST_EN
      r_hbit       <= 1'b0;
`endif
    end else begin
      r_run        <= 1'b1;
      r_duty_valid <= 1'b0;
      if (!bus.en) begin
        // Abort: a partial average is dropped, duty code is held.
        r_state <= ST_ACCUM;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_ACCUM: begin
            if (w_accept) begin
              r_acc <= r_acc + ACC_W'(bus.sample_data);
              r_cnt <= r_cnt + AVG_LOG2'(1);
              // Counter all-ones means this is sample 2^AVG_LOG2.
              if (&r_cnt) begin
                r_state <= ST_MAP;
              end
            end
          end
          ST_MAP: begin
            // Top three bits of (acc >> AVG_LOG2) are the top three of acc.
            r_cand  <= r_acc[ACC_W-1 -: 3];
`ifdef ADC_DUTY_HYST_EN
            r_hbit  <= r_acc[ACC_W-4];
`endif
            r_state <= ST_UPDATE;
          end
          ST_UPDATE: begin
            r_duty       <= w_next_duty;
            r_duty_valid <= 1'b1;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_state      <= ST_ACCUM;
          end
          default: begin
            r_state <= ST_ACCUM;
          end
        endcase
      end
    end
  end

  assign bus.sample_ready = w_ready;
  assign bus.duty_cycle   = r_duty;
  assign bus.duty_valid   = r_duty_valid;

endmodule
`default_nettype wire

// File: tb/tb_adc_duty_map.sv
`default_nettype none
// ============================================================================
// Module    : tb_adc_duty_map
// Purpose   : Self-checking bench for adc_duty_map (ADC_WIDTH=12,
//             AVG_LOG2=3). A behavioural model tracks accepted samples as a
//             running sum and predicts ready / duty_valid / duty_cycle every
//             cycle; directed sequences pin the model with literal values,
//             followed by a randomized phase. Honours ADC_DUTY_HYST_EN.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_adc_duty_map;

  localparam int W = 12;
  localparam int L = 3;
  localparam int N = 1 << L;

`ifdef ADC_DUTY_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  adc_duty_map_if #(.ADC_WIDTH(W)) bus ();

  adc_duty_map #(.ADC_WIDTH(W), .AVG_LOG2(L)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_live = 1'b0;
  bit       m_run;
  int       m_sum, m_cnt, m_pend, m_avg;
  int       m_duty;
  bit       m_dv;
  int       dv_count = 0;

  function automatic int next_duty(input int cur, input int avg);
    int cand, fine;
    cand = avg >> (W - 3);
    fine = (avg >> (W - 4)) & 1;
    if (HYST) begin
      if (cand == cur + 1) return (fine == 1) ? cand : cur;
      if (cand == cur - 1) return (fine == 0) ? cand : cur;
    end
    return cand;
  endfunction

  // Outputs are compared at the negedge; then the model advances by the
  // effect of the coming posedge using the inputs that edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_live = 1'b1;
      m_run  = 1'b0;
      m_sum  = 0; m_cnt = 0; m_pend = 0; m_avg = 0;
      m_duty = 0; m_dv = 1'b0;
      chk("rst_ready", int'(bus.sample_ready), 0);
      chk("rst_dv",    int'(bus.duty_valid),   0);
      chk("rst_duty",  int'(bus.duty_cycle),   0);
    end else if (m_live) begin
      chk("model_ready", int'(bus.sample_ready), int'(m_run && bus.en && m_pend == 0));
      chk("model_dv",    int'(bus.duty_valid),   int'(m_dv));
      chk("model_duty",  int'(bus.duty_cycle),   m_duty);
      if (bus.duty_valid) dv_count++;
      if (!bus.en) begin
        m_sum = 0; m_cnt = 0; m_pend = 0; m_dv = 1'b0;
      end else begin
        m_dv = 1'b0;
        if (m_pend > 0) begin
          m_pend--;
          if (m_pend == 0) begin
            m_duty = next_duty(m_duty, m_avg);
            m_dv   = 1'b1;
          end
        end else if (m_run && bus.sample_valid) begin
          m_sum += int'(bus.sample_data);
          m_cnt++;
          if (m_cnt == N) begin
            m_avg  = m_sum / N;
            m_sum  = 0;
            m_cnt  = 0;
            m_pend = 2;
          end
        end
      end
      m_run = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offers d until n samples are accepted; returns 1 time unit after the
  // edge that took the last one.
  task automatic send(input logic [W-1:0] d, input int n);
    int got = 0;
    int guard = 0;
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    while (got < n && guard < 200) begin
      @(negedge clk);
      if (bus.sample_ready) got++;
      @(posedge clk); #1;
      guard++;
    end
    bus.sample_valid = 1'b0;
    chk("send_accepts", got, n);
  endtask

  // Called right after the last accept (edge N): checks the two-edge latency.
  task automatic wait_update(input string nm, input int d);
    chk({nm, "_dv_e0"},    int'(bus.duty_valid),   0);
    chk({nm, "_rdy_e0"},   int'(bus.sample_ready), 0);
    @(posedge clk); #1;
    chk({nm, "_dv_e1"},    int'(bus.duty_valid),   0);
    chk({nm, "_rdy_e1"},   int'(bus.sample_ready), 0);
    @(posedge clk); #1;
    chk({nm, "_dv_e2"},    int'(bus.duty_valid),   1);
    chk({nm, "_duty_e2"},  int'(bus.duty_cycle),   d);
    chk({nm, "_rdy_e2"},   int'(bus.sample_ready), 1);
    @(posedge clk); #1;
    chk({nm, "_dv_e3"},    int'(bus.duty_valid),   0);
    chk({nm, "_duty_e3"},  int'(bus.duty_cycle),   d);
  endtask

  initial begin
    int dv0, acc_n, low_n, dv_n, base;
    rst_n            = 1'b1;
    bus.en           = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full scale -> 7
    send(12'hFFF, 8);
    wait_update("full", 7);
    // Mid scale after 7 -> 4 (large step, always adopted)
    send(12'h800, 8);
    wait_update("mid", 4);
    // One step up with fine bit clear, then with fine bit set
    send(12'hA00, 8);
    wait_update("up_lo", HYST ? 4 : 5);
    send(12'hB00, 8);
    wait_update("up_hi", 5);

    // Partial average aborted by a one-cycle en drop
    send(12'hFFF, 5);
    bus.en = 1'b0;
    @(posedge clk); #1;
    bus.en = 1'b1;
    dv0 = dv_count;
    send(12'h000, 8);
    chk("abort_no_early_dv", dv_count - dv0, 0);
    wait_update("abort", 0);

    // Reset in the middle of an average
    send(12'h800, 8);
    wait_update("pre_rst", 4);
    send(12'hFFF, 4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_duty",  int'(bus.duty_cycle),   0);
    chk("async_rst_dv",    int'(bus.duty_valid),   0);
    chk("async_rst_ready", int'(bus.sample_ready), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(12'h400, 8);
    wait_update("post_rst", 2);

    // Continuous valid: 8 accepts then two not-ready cycles per update
    acc_n = 0; low_n = 0; dv_n = 0;
    bus.sample_data  = 12'h600;
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.sample_ready) acc_n++; else low_n++;
      if (bus.duty_valid) dv_n++;
    end
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    chk("stream_accepts",   acc_n, 24);
    chk("stream_low_cycles", low_n, 6);
    chk("stream_dv_pulses", dv_n, 2);
    repeat (3) @(posedge clk);
    #1;

    // Randomized phase: burst bases near bin edges, valid gaps, rare en drops
    base = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) base = int'($urandom_range(0, 15)) * 256 - 64;
      bus.en           = ($urandom_range(0, 59) != 0);
      bus.sample_valid = ($urandom_range(0, 3) != 0);
      begin
        int v;
        v = base + int'($urandom_range(0, 160));
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        bus.sample_data = W'(v);
      end
      @(posedge clk); #1;
    end
    bus.en = 1'b1;
    bus.sample_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("saw_random_updates", int'(dv_count > 20), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
